// File: rtl/parser_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parser_input_arbiter
// Purpose  : Packet-level 2:1 AXI-Stream arbiter feeding riscv_parser through
//            a single-entry output register (full throughput, 1-cycle latency).
// Options  : PARSER_ARB_STRICT_PRIO_EN - s0 always wins contention in IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module parser_input_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              areset,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [1:0]                        grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_out_ready;
    logic   w_acc0;
    logic   w_acc1;
    logic   w_load;
    logic   w_pick1;

    assign w_out_ready    = !m_axis_tvalid || m_axis_tready;
    assign s0_axis_tready = (r_state == GRANT0) && w_out_ready;
    assign s1_axis_tready = (r_state == GRANT1) && w_out_ready;
    assign w_acc0         = s0_axis_tvalid && s0_axis_tready;
    assign w_acc1         = s1_axis_tvalid && s1_axis_tready;
    assign w_load         = w_acc0 || w_acc1;
    assign grant          = {r_state == GRANT1, r_state == GRANT0};

`ifdef PARSER_ARB_STRICT_PRIO_EN
    assign w_pick1 = 1'b0;
`else
    // Remembers who finished the last packet; reset to 1 so s0 wins first.
    logic r_last_served;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_last_served <= 1'b1;
        end else if (w_acc0 && s0_axis_tlast) begin
            r_last_served <= 1'b0;
        end else if (w_acc1 && s1_axis_tlast) begin
            r_last_served <= 1'b1;
        end
    end

    assign w_pick1 = !r_last_served;
`endif

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid) begin
                    w_next_state = w_pick1 ? GRANT1 : GRANT0;
                end else if (s0_axis_tvalid) begin
                    w_next_state = GRANT0;
                end else if (s1_axis_tvalid) begin
                    w_next_state = GRANT1;
                end
            end
            GRANT0: begin
                if (w_acc0 && s0_axis_tlast) begin
                    w_next_state = IDLE;
                end
            end
            GRANT1: begin
                if (w_acc1 && s1_axis_tlast) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A load and a drain in the same cycle simply replaces the held beat.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (w_load) begin
            m_axis_tdata  <= w_acc1 ? s1_axis_tdata : s0_axis_tdata;
            m_axis_tkeep  <= w_acc1 ? s1_axis_tkeep : s0_axis_tkeep;
            m_axis_tuser  <= w_acc1 ? s1_axis_tuser : s0_axis_tuser;
            m_axis_tlast  <= w_acc1 ? s1_axis_tlast : s0_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parser_input_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_parser_input_arbiter
// Purpose  : Self-checking bench for parser_input_arbiter (packet table,
//            contention, backpressure, source gap, reset, frame passthrough).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_parser_input_arbiter;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        int         src;
        int         len;
        logic [1:0] exp_grant;
    } row_t;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic [UW-1:0] s0_axis_tuser, s1_axis_tuser, m_axis_tuser;
    logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [1:0]    grant;

    beat_t q0[$];
    beat_t q1[$];
    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    mon_count = 0;
    logic  mon_en = 1'b1;
    logic  gap1 = 1'b0;
    logic  bp_en = 1'b0;

    parser_input_arbiter #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .s0_axis_tdata (s0_axis_tdata),
        .s0_axis_tkeep (s0_axis_tkeep),
        .s0_axis_tuser (s0_axis_tuser),
        .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast (s0_axis_tlast),
        .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata (s1_axis_tdata),
        .s1_axis_tkeep (s1_axis_tkeep),
        .s1_axis_tuser (s1_axis_tuser),
        .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast (s1_axis_tlast),
        .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .grant         (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int src, input int tag, input int i, input int len);
        beat_t b;
        for (int w = 0; w < DW / 32; w++) begin
            b.data[32*w +: 32] = {src[3:0], tag[11:0], w[7:0], i[7:0]};
        end
        b.keep = (i == len - 1) ? ({KW{1'b1}} >> (tag % 8)) : {KW{1'b1}};
        b.user = {(UW / 32){tag[15:0], i[7:0], src[7:0]}};
        b.last = (i == len - 1);
        return b;
    endfunction

    task automatic push_pkt(input int src, input int tag, input int len, input bit to_exp);
        for (int i = 0; i < len; i++) begin
            if (src == 0) q0.push_back(mk(src, tag, i, len));
            else          q1.push_back(mk(src, tag, i, len));
            if (to_exp) exp_q.push_back(mk(src, tag, i, len));
        end
    endtask

    task automatic push_exp(input int src, input int tag, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(mk(src, tag, i, len));
    endtask

    task automatic wait_done(input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            done = (q0.size() == 0) && (q1.size() == 0) && (exp_q.size() == 0) && !m_axis_tvalid;
        end
        chk("drain_within_budget", DW'(done), DW'(1'b1));
    endtask

    task automatic wait_hs(input int src, input int budget);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            hit = (src == 0) ? (s0_axis_tvalid && s0_axis_tready) : (s1_axis_tvalid && s1_axis_tready);
        end
        chk("handshake_within_budget", DW'(hit), DW'(1'b1));
    endtask

    task automatic wait_grant(input logic [1:0] g, input int budget);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            hit = (grant == g);
        end
        chk("grant_within_budget", DW'(hit), DW'(1'b1));
    endtask

    // Source drivers: present the queue head, pop it after a handshake.
    initial begin : drv0
        logic hs;
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
        s0_axis_tuser = '0; s0_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs = s0_axis_tvalid && s0_axis_tready;
            @(posedge clk);
            #1;
            if (hs && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                s0_axis_tvalid = 1'b1;
                s0_axis_tdata = q0[0].data; s0_axis_tkeep = q0[0].keep;
                s0_axis_tuser = q0[0].user; s0_axis_tlast = q0[0].last;
            end else begin
                s0_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin : drv1
        logic hs;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
        s1_axis_tuser = '0; s1_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            hs = s1_axis_tvalid && s1_axis_tready;
            @(posedge clk);
            #1;
            if (hs && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0 && !gap1) begin
                s1_axis_tvalid = 1'b1;
                s1_axis_tdata = q1[0].data; s1_axis_tkeep = q1[0].keep;
                s1_axis_tuser = q1[0].user; s1_axis_tlast = q1[0].last;
            end else begin
                s1_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin : sink
        logic [1:0] bp_idx;
        logic [3:0] bp_pat;
        bp_idx = 2'd0;
        bp_pat = 4'b1001;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_axis_tready = bp_pat[bp_idx];
                bp_idx = bp_idx + 2'd1;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pop, hold-while-stalled and no-accept-when-full.
    initial begin : mon
        logic  stall_prev;
        beat_t held, got, exp;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (areset) begin
                stall_prev = 1'b0;
            end else begin
                got = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser, last: m_axis_tlast};
                if (stall_prev) begin
                    chk("stall_valid_held", DW'(m_axis_tvalid), DW'(1'b1));
                    chk("stall_data_held", got.data, held.data);
                    chk("stall_ctrl_held", DW'({got.keep, got.user, got.last}), DW'({held.keep, held.user, held.last}));
                end
                if (m_axis_tvalid && !m_axis_tready) begin
                    chk("tready_low_when_full", DW'({s1_axis_tready, s0_axis_tready}), DW'(2'b00));
                end
                if (m_axis_tvalid && m_axis_tready && mon_en) begin
                    mon_count++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_beat", DW'(1'b1), DW'(1'b0));
                    end else begin
                        exp = exp_q.pop_front();
                        chk("out_tdata", got.data, exp.data);
                        chk("out_tkeep", DW'(got.keep), DW'(exp.keep));
                        chk("out_tuser", DW'(got.user), DW'(exp.user));
                        chk("out_tlast", DW'(got.last), DW'(exp.last));
                    end
                end
                stall_prev = m_axis_tvalid && !m_axis_tready;
                held = got;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        row_t          rows [5];
        logic [7:0]    fb [KW];
        logic [DW-1:0] frame;
        beat_t         fbeat;
        int            cnt0;

        rows[0] = '{src: 0, len: 5, exp_grant: 2'b01};
        rows[1] = '{src: 1, len: 1, exp_grant: 2'b10};
        rows[2] = '{src: 0, len: 1, exp_grant: 2'b01};
        rows[3] = '{src: 1, len: 3, exp_grant: 2'b10};
        rows[4] = '{src: 0, len: 2, exp_grant: 2'b01};

        repeat (3) @(negedge clk);
        chk("rst_m_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("rst_m_tlast", DW'(m_axis_tlast), DW'(1'b0));
        chk("rst_m_tdata", m_axis_tdata, '0);
        chk("rst_m_tkeep_tuser", DW'({m_axis_tkeep, m_axis_tuser}), '0);
        chk("rst_grant", DW'(grant), DW'(2'b00));
        chk("rst_s_tready", DW'({s1_axis_tready, s0_axis_tready}), DW'(2'b00));
        areset = 1'b0;
        @(negedge clk);

        // Single-requester packets: arbitration cycle, grant, beat count, release.
        for (int r = 0; r < 5; r++) begin
            cnt0 = mon_count;
            push_pkt(rows[r].src, r + 1, rows[r].len, 1'b1);
            @(posedge clk);
            @(negedge clk);
            chk("idle_no_accept", DW'({s1_axis_tready, s0_axis_tready}), DW'(2'b00));
            chk("idle_grant", DW'(grant), DW'(2'b00));
            @(negedge clk);
            chk("grant_after_valid", DW'(grant), DW'(rows[r].exp_grant));
            wait_done(100);
            chk("beat_count", DW'(mon_count - cnt0), DW'(rows[r].len));
            chk("grant_released", DW'(grant), DW'(2'b00));
        end

        // Contention from a fresh reset: s0 is served first.
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 10 + p, 2, 1'b0);
            push_pkt(1, 20 + p, 2, 1'b0);
        end
`ifdef PARSER_ARB_STRICT_PRIO_EN
        for (int p = 0; p < 3; p++) push_exp(0, 10 + p, 2);
        for (int p = 0; p < 3; p++) push_exp(1, 20 + p, 2);
`else
        for (int p = 0; p < 3; p++) begin
            push_exp(0, 10 + p, 2);
            push_exp(1, 20 + p, 2);
        end
`endif
        wait_done(300);

        // Backpressure 1,0,0,1 on two 4-beat packets.
        bp_en = 1'b1;
        push_pkt(0, 30, 4, 1'b1);
        push_pkt(1, 31, 4, 1'b1);
        wait_done(300);
        bp_en = 1'b0;
        @(negedge clk);

        // s1 pauses mid-packet while s0 is waiting.
        push_pkt(1, 40, 4, 1'b1);
        wait_grant(2'b10, 20);
        wait_hs(1, 20);
        gap1 = 1'b1;
        push_pkt(0, 41, 2, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("gap_grant_held", DW'(grant), DW'(2'b10));
            chk("gap_s0_blocked", DW'(s0_axis_tready), DW'(1'b0));
        end
        gap1 = 1'b0;
        wait_done(200);

        // Reset on beat 2 of 4 takes effect without a clock edge.
        mon_en = 1'b0;
        push_pkt(0, 50, 4, 1'b0);
        wait_hs(0, 20);
        @(negedge clk);
        areset = 1'b1;
        #1;
        chk("async_rst_m_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("async_rst_grant", DW'(grant), DW'(2'b00));
        chk("async_rst_s0_tready", DW'(s0_axis_tready), DW'(1'b0));
        q0.delete();
        q1.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        areset = 1'b0;
        mon_en = 1'b1;
        push_pkt(1, 51, 2, 1'b0);
        push_pkt(0, 52, 2, 1'b0);
        push_exp(0, 52, 2);
        push_exp(1, 51, 2);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_first_grant", DW'(grant), DW'(2'b01));
        wait_done(100);

        // 512-bit IPv4/UDP frame (dst port 0xf1f2) through s1.
        for (int i = 0; i < KW; i++) fb[i] = 8'(i * 7 + 3);
        fb[0] = 8'h02; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h01;
        fb[6] = 8'h02; fb[7] = 8'h00; fb[8] = 8'h00; fb[9] = 8'h00; fb[10] = 8'h00; fb[11] = 8'h02;
        fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = 8'h00; fb[16] = 8'h00; fb[17] = 8'h32;
        fb[22] = 8'h40; fb[23] = 8'h11;
        fb[26] = 8'hc0; fb[27] = 8'ha8; fb[28] = 8'h00; fb[29] = 8'h01;
        fb[30] = 8'hc0; fb[31] = 8'ha8; fb[32] = 8'h00; fb[33] = 8'h02;
        fb[34] = 8'h12; fb[35] = 8'h34; fb[36] = 8'hf1; fb[37] = 8'hf2;
        for (int i = 0; i < KW; i++) frame[8*i +: 8] = fb[i];
        fbeat.data = frame;
        fbeat.keep = {KW{1'b1}};
        fbeat.user = {32'hdead_beef, 32'h0000_f1f2, 32'h0123_4567, 32'h89ab_cdef};
        fbeat.last = 1'b1;
        q1.push_back(fbeat);
        exp_q.push_back(fbeat);
        wait_hs(1, 20);
        @(negedge clk);
        chk("frame_valid_next_cycle", DW'(m_axis_tvalid), DW'(1'b1));
        chk("frame_tdata", m_axis_tdata, frame);
        chk("frame_tkeep_tuser", DW'({m_axis_tkeep, m_axis_tuser}), DW'({fbeat.keep, fbeat.user}));
        wait_done(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
